// File: rtl/pe_operand_join.sv
// Operand-join stage: three per-channel operand FIFOs feeding one registered
// triple to the PE ALU once every operand the configured op needs is present.

module pe_operand_join_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_cnt;
  logic             r_rdy;

  logic             w_push;
  logic             w_pop;
  logic [CW-1:0]    w_cnt_nxt;

  assign w_push    = i_valid && r_rdy;
  assign w_pop     = i_pop && (r_cnt != '0);
  assign w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);

  assign o_ready = r_rdy;
  assign o_head  = r_mem[r_rptr];
  assign o_empty = (r_cnt == '0);

  // Ready is a flop so it never depends on the same-cycle pop or valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_rdy  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_cnt <= w_cnt_nxt;
      r_rdy <= (w_cnt_nxt != FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

module pe_operand_join #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 2,
  parameter int NoConfigBits = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        in1_data,
  input  logic                    in1_valid,
  output logic                    in1_ready,
  input  logic [WIDTH-1:0]        in2_data,
  input  logic                    in2_valid,
  output logic                    in2_ready,
  input  logic [WIDTH-1:0]        in3_data,
  input  logic                    in3_valid,
  output logic                    in3_ready,
  input  logic [NoConfigBits-1:0] OP_MASK,
  output logic [WIDTH-1:0]        data_out1,
  output logic [WIDTH-1:0]        data_out2,
  output logic [WIDTH-1:0]        data_out3,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0] w_in_data [3];
  logic [2:0]       w_in_valid;
  logic [2:0]       w_in_ready;
  logic [WIDTH-1:0] w_head [3];
  logic [2:0]       w_empty;
  logic [2:0]       w_mask;
  logic [2:0]       w_pop;
  logic             w_have;
  logic             w_fire;

  logic [WIDTH-1:0] r_d1;
  logic [WIDTH-1:0] r_d2;
  logic [WIDTH-1:0] r_d3;
  logic             r_ov;

  assign w_in_data[0] = in1_data;
  assign w_in_data[1] = in2_data;
  assign w_in_data[2] = in3_data;
  assign w_in_valid   = {in3_valid, in2_valid, in1_valid};
  assign in1_ready    = w_in_ready[0];
  assign in2_ready    = w_in_ready[1];
  assign in3_ready    = w_in_ready[2];

  assign w_mask = OP_MASK[2:0];
  assign w_have = &(~w_mask | ~w_empty);
  assign w_fire = (w_mask != 3'b000) && w_have && (!r_ov || out_ready);
  assign w_pop  = w_mask & {3{w_fire}};

  for (genvar k = 0; k < 3; k++) begin : g_ch
    pe_operand_join_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_data  (w_in_data[k]),
      .i_valid (w_in_valid[k]),
      .o_ready (w_in_ready[k]),
      .i_pop   (w_pop[k]),
      .o_head  (w_head[k]),
      .o_empty (w_empty[k])
    );
  end

  // Unused operand slots are zeroed so the ALU sees a clean bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d1 <= '0;
      r_d2 <= '0;
      r_d3 <= '0;
      r_ov <= 1'b0;
    end else if (w_fire) begin
      r_d1 <= w_mask[0] ? w_head[0] : '0;
      r_d2 <= w_mask[1] ? w_head[1] : '0;
      r_d3 <= w_mask[2] ? w_head[2] : '0;
      r_ov <= 1'b1;
    end else if (out_ready) begin
      r_ov <= 1'b0;
    end
  end

  assign data_out1 = r_d1;
  assign data_out2 = r_d2;
  assign data_out3 = r_d3;
  assign out_valid = r_ov;

endmodule
